// File: rtl/i2c_target_if.sv
// CPU-side rib register bus of the I2C target: write strobe, address, write data, combinational read data.
interface i2c_target_if;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output we_i, addr_i, data_i, input data_o);
    modport slave  (input we_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/i2c_target.sv
// I2C target with a 4-byte register bank shared with the CPU rib bus; SCL/SDA oversampled on clk, never stretches SCL.
// Latency: ~3 clk from a pad edge to the response; no backpressure, rib accesses always complete in one cycle.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         scl_i,
    input  logic         sda_i,
    output logic         sda_oe_o,
    output logic         wr_pulse_o,
    i2c_target_if.slave  rib
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, WR_BYTE, ACK_WR, RD_BYTE, RD_ACK
    } state_t;

    state_t      state;
    logic [2:0]  scl_sync;
    logic [2:0]  sda_sync;
    logic [7:0]  shreg;
    logic [3:0]  bitcnt;
    logic [1:0]  ptr;
    logic        first;
    logic        nack;
    logic [7:0]  bank [4];

    // [1] is the synchronized level, [2] the previous level for edge detection
    logic scl_rise, scl_fall, start_det, stop_det, sda_s;
    assign sda_s     = sda_sync[1];
    assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
    assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
    assign start_det =  scl_sync[1] &  scl_sync[2] & ~sda_sync[1] &  sda_sync[2];
    assign stop_det  =  scl_sync[1] &  scl_sync[2] &  sda_sync[1] & ~sda_sync[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync   <= 3'b111;
            sda_sync   <= 3'b111;
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            ptr        <= '0;
            first      <= 1'b0;
            nack       <= 1'b0;
            sda_oe_o   <= 1'b0;
            wr_pulse_o <= 1'b0;
            for (int i = 0; i < 4; i++) bank[i] <= '0;
        end else begin
            scl_sync   <= {scl_sync[1:0], scl_i};
            sda_sync   <= {sda_sync[1:0], sda_i};
            wr_pulse_o <= 1'b0;

            // CPU write first so an I2C write to the same byte this cycle overrides it
            if (rib.we_i && !rib.addr_i[4])
                bank[rib.addr_i[3:2]] <= rib.data_i[7:0];

            if (start_det) begin
                state    <= ADDR;
                bitcnt   <= '0;
                sda_oe_o <= 1'b0;
            end else if (stop_det) begin
                state    <= IDLE;
                sda_oe_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: ;
                    ADDR: begin
                        if (scl_rise) begin
                            shreg  <= {shreg[6:0], sda_s};
                            bitcnt <= bitcnt + 4'd1;
                        end else if (scl_fall && bitcnt == 4'd8) begin
                            if (shreg[7:1] == TARGET_ADDR) begin
                                state    <= ACK_ADDR;
                                sda_oe_o <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    ACK_ADDR: begin
                        if (scl_fall) begin
                            bitcnt <= '0;
                            if (shreg[0]) begin
                                shreg    <= bank[ptr];
                                sda_oe_o <= ~bank[ptr][7];
                                state    <= RD_BYTE;
                            end else begin
                                sda_oe_o <= 1'b0;
                                first    <= 1'b1;
                                state    <= WR_BYTE;
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise) begin
                            shreg  <= {shreg[6:0], sda_s};
                            bitcnt <= bitcnt + 4'd1;
                        end else if (scl_fall && bitcnt == 4'd8) begin
                            if (first) begin
                                ptr   <= shreg[1:0];
                                first <= 1'b0;
                            end else begin
                                bank[ptr]  <= shreg;
                                ptr        <= ptr + 2'd1;
                                wr_pulse_o <= 1'b1;
                            end
                            bitcnt   <= '0;
                            sda_oe_o <= 1'b1;
                            state    <= ACK_WR;
                        end
                    end
                    ACK_WR: begin
                        if (scl_fall) begin
                            sda_oe_o <= 1'b0;
                            state    <= WR_BYTE;
                        end
                    end
                    RD_BYTE: begin
                        // bit 7 went out on entry; each fall presents the next bit
                        if (scl_fall) begin
                            if (bitcnt == 4'd7) begin
                                sda_oe_o <= 1'b0;
                                ptr      <= ptr + 2'd1;
                                state    <= RD_ACK;
                            end else begin
                                shreg    <= {shreg[6:0], 1'b0};
                                sda_oe_o <= ~shreg[6];
                                bitcnt   <= bitcnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            nack <= sda_s;
                        end else if (scl_fall) begin
                            if (!nack) begin
                                shreg    <= bank[ptr];
                                sda_oe_o <= ~bank[ptr][7];
                                bitcnt   <= '0;
                                state    <= RD_BYTE;
                            end else begin
                                sda_oe_o <= 1'b0;
                                state    <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic        busy;
    logic [1:0]  rd_idx;
    logic [31:0] rd_dat;
    assign busy   = (state != IDLE);
    assign rd_idx = rib.addr_i[3:2];

    always_comb begin
        rd_dat = '0;
        if (rst_n) begin
            if (!rib.addr_i[4])
                rd_dat = {24'b0, bank[rd_idx]};
            else if (rd_idx == 2'd0)
                rd_dat = {28'b0, ptr, 1'b0, busy};
        end
    end
    assign rib.data_o = rd_dat;

    logic unused_rib;
    assign unused_rib = ^{rib.addr_i[31:5], rib.addr_i[1:0], rib.data_i[31:8]};

endmodule
